// File: rtl/calc_disp_pkg.sv
// ---------------------------------------------------------------------------
// calc_disp_pkg
// Shared definitions for the calculator result display path:
//   - active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   - 4-bit digit code (0..9 numeric, plus minus/blank/E/r symbols)
//   - 2-bit scan index and the helpers that step it and decode it to an
// ---------------------------------------------------------------------------
package calc_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    // Codes 0..9 are the numeric digits themselves.
    typedef logic [3:0] digit_t;

    localparam digit_t DIG_MINUS = 4'd10;
    localparam digit_t DIG_BLANK = 4'd11;
    localparam digit_t DIG_E     = 4'd12;
    localparam digit_t DIG_R     = 4'd13;

    typedef enum logic [1:0] {
        SCAN_ONES = 2'd0,
        SCAN_TENS = 2'd1,
        SCAN_SIGN = 2'd2
    } scan_idx_t;

    function automatic scan_idx_t scan_next(input scan_idx_t idx);
        case (idx)
            SCAN_ONES: return SCAN_TENS;
            SCAN_TENS: return SCAN_SIGN;
            default:   return SCAN_ONES;
        endcase
    endfunction

    // One-hot-low digit enable: an[0]=ones, an[1]=tens, an[2]=sign.
    function automatic logic [2:0] scan_an(input scan_idx_t idx);
        case (idx)
            SCAN_ONES: return 3'b110;
            SCAN_TENS: return 3'b101;
            default:   return 3'b011;
        endcase
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// ---------------------------------------------------------------------------
// seg7_encode
// Combinational map from a digit code to active-low 7-segment drive.
// Ports:
//   digit_i  digit code (0..9, DIG_MINUS, DIG_BLANK, DIG_E, DIG_R)
//   seg_o    segments {g,f,e,d,c,b,a}, active-low
// Unused codes decode to blank.
// ---------------------------------------------------------------------------
module seg7_encode
    import calc_disp_pkg::*;
(
    input  digit_t     digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:      seg_o = SEG_0;
            4'd1:      seg_o = SEG_1;
            4'd2:      seg_o = SEG_2;
            4'd3:      seg_o = SEG_3;
            4'd4:      seg_o = SEG_4;
            4'd5:      seg_o = SEG_5;
            4'd6:      seg_o = SEG_6;
            4'd7:      seg_o = SEG_7;
            4'd8:      seg_o = SEG_8;
            4'd9:      seg_o = SEG_9;
            DIG_MINUS: seg_o = SEG_MINUS;
            DIG_E:     seg_o = SEG_E;
            DIG_R:     seg_o = SEG_R;
            default:   seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display_ctrl.sv
// ---------------------------------------------------------------------------
// result_display_ctrl
// Captures the 5-bit signed ALU result on a load strobe, converts it to
// sign + tens + ones digit codes, and scans the three digits onto a shared
// active-low 7-segment bus. An invalid-op load shows "Err".
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst_n       synchronous active-low reset
//   result      signed ALU result, -16..+15
//   load        single-cycle strobe: capture result/err this cycle
//   err         sampled with load; 1 = invalid op
//   seg         segments {g,f,e,d,c,b,a}, active-low, registered
//   an          digit enables, active-low, registered (an[0]=ones)
//   disp_valid  high from the first conversion after reset onward
//
// Pipeline: capture (hold_*) -> convert (dig_*) -> seg/an output registers.
//
// Scan index:
//   state     | meaning
//   SCAN_ONES | ones digit enabled next (an=110)
//   SCAN_TENS | tens digit enabled next (an=101)
//   SCAN_SIGN | sign digit enabled next (an=011)
// The index steps when the refresh counter wraps at REFRESH_CNT-1.
// ---------------------------------------------------------------------------
module result_display_ctrl
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_CNT = 50000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] result,
    input  logic       load,
    input  logic       err,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       disp_valid
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [4:0]       hold_val_q;
    logic             hold_err_q;
    logic             cap_q;
    digit_t           dig_ones_q, dig_tens_q, dig_sign_q;
    logic             disp_valid_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    scan_idx_t        idx_q, idx_d;
    logic [6:0]       seg_q;
    logic [2:0]       an_q;

    // Conversion of the held value into digit codes.
    logic [4:0] mag;
    logic       tens_nz;
    logic [3:0] ones_val;
    digit_t     dig_ones_d, dig_tens_d, dig_sign_d;

    always_comb begin
        // Negating 5'b10000 gives 5'b10000, which read unsigned is 16.
        mag      = hold_val_q[4] ? (5'd0 - hold_val_q) : hold_val_q;
        tens_nz  = (mag >= 5'd10);
        ones_val = tens_nz ? 4'(mag - 5'd10) : mag[3:0];

        dig_sign_d = DIG_BLANK;
        dig_tens_d = DIG_BLANK;
        dig_ones_d = DIG_BLANK;
        if (hold_err_q) begin
            dig_sign_d = DIG_E;
            dig_tens_d = DIG_R;
            dig_ones_d = DIG_R;
        end else begin
            dig_sign_d = hold_val_q[4] ? DIG_MINUS : DIG_BLANK;
            dig_tens_d = tens_nz ? digit_t'(4'd1) : DIG_BLANK;
            dig_ones_d = ones_val;
        end
    end

    // Refresh counter and scan index next state.
    logic cnt_wrap;

    always_comb begin
        cnt_wrap = (cnt_q == CNT_LAST);
        cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_ONE;
        idx_d    = cnt_wrap ? scan_next(idx_q) : idx_q;
    end

    // Digit feeding the encoder; an_q and seg_q both load from idx_q so
    // the enable and the segment pattern always switch together.
    digit_t     sel_dig;
    logic [6:0] seg_enc;

    always_comb begin
        case (idx_q)
            SCAN_ONES: sel_dig = dig_ones_q;
            SCAN_TENS: sel_dig = dig_tens_q;
            default:   sel_dig = dig_sign_q;
        endcase
    end

    seg7_encode u_seg7_encode (
        .digit_i (sel_dig),
        .seg_o   (seg_enc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_val_q   <= '0;
            hold_err_q   <= 1'b0;
            cap_q        <= 1'b0;
            dig_ones_q   <= DIG_BLANK;
            dig_tens_q   <= DIG_BLANK;
            dig_sign_q   <= DIG_BLANK;
            disp_valid_q <= 1'b0;
            cnt_q        <= '0;
            idx_q        <= SCAN_ONES;
            seg_q        <= SEG_BLANK;
            an_q         <= 3'b111;
        end else begin
            if (load) begin
                hold_val_q <= result;
                hold_err_q <= err;
            end
            cap_q <= load;

            // All three digits update together from one hold value, so
            // back-to-back loads never leave a mixed display.
            if (cap_q) begin
                dig_ones_q   <= dig_ones_d;
                dig_tens_q   <= dig_tens_d;
                dig_sign_q   <= dig_sign_d;
                disp_valid_q <= 1'b1;
            end

            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= scan_an(idx_q);
            seg_q <= seg_enc;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign disp_valid = disp_valid_q;

endmodule

// File: doc/result_display_ctrl.md
Name: result_display_ctrl

Overview:
- Downstream consumer of the 3-bit signed calculator ALU.
- Captures the 5-bit signed result on a load strobe and converts it to sign plus two decimal digits.
- Time-multiplexes those three digits onto a common 7-segment bus for the board display.
- Shows "Err" when the upstream op is invalid.

Parameters:
- REFRESH_CNT, 50000, clock cycles each digit stays enabled before the scan advances (>=2).
- CNT_W, 16, width of the refresh counter; must satisfy 2**CNT_W >= REFRESH_CNT.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- result  input  5  signed ALU result, range -16..+15.
- load  input  1  single-cycle strobe: capture result/err this cycle.
- err  input  1  sampled only with load; 1 = invalid op (ALU op 2'b11).
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  3  digit enables, active-low; an[0]=ones, an[1]=tens, an[2]=sign.
- disp_valid  output  1  high once a loaded value has reached the digit registers.

Behaviour:
- Single clock domain. Reset is synchronous, active-low: when rst_n=0 at a rising edge, every register takes its reset value.
- Reset values:
  - seg=7'h7F, an=3'b111, disp_valid=0.
  - Hold register=0, hold err=0, digit registers all blank.
  - Refresh counter=0, scan index=0.
- Stage 1, capture: on load=1, hold_val<=result and hold_err<=err. With load=0, hold is unchanged.
- Stage 2, convert (registered, the cycle after capture):
  - mag=|hold_val| as 5-bit unsigned; -16 -> 16, no overflow.
  - tens=(mag>=10), ones=mag-10*tens.
  - sign digit = '-' if negative, else blank.
  - tens digit = blank if tens==0 (leading-zero blanking), else '1'.
  - ones digit always shown, including '0'.
  - If hold_err: digits are sign='E', tens='r', ones='r'; the numeric value is ignored.
- Latency: load at edge N -> digit registers updated at edge N+2, and disp_valid=1 from edge N+2 onward. disp_valid stays 1 until the next reset.
- Back-to-back loads: every load is captured and the pipeline runs each one in order. The display settles to the last loaded value, and no mix of digits from different loads ever appears in the digit registers.
- Scan:
  - The counter increments every cycle and wraps at REFRESH_CNT-1 to 0.
  - On wrap, the scan index advances 0->1->2->0.
  - an is registered one-hot-low from the index: 0->3'b110, 1->3'b101, 2->3'b011.
  - seg is registered from the digit selected by the same index, so seg and an always change on the same edge.
- First cycle after rst_n rises: an=3'b110, seg=blank (7'h7F) until disp_valid.
- Reset mid-scan or mid-conversion: all state returns to reset values at that edge. Pending loads are discarded.
- Segment codes, active-low gfedcba:
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Symbols: '-'=3F, blank=7F, E=06, r=2F.

Decomposition:
- Package calc_disp_pkg holds:
  - Segment encoding constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK, SEG_E, SEG_R.
  - A 4-bit digit-code typedef with symbolic codes for minus, blank, E and r.
  - A 2-bit scan-index typedef.
- One combinational sub-module, seg7_encode, maps a digit code to seg. Stage 2 stores digit codes; seg7_encode sits before the seg output register.

Test Plan (bench uses REFRESH_CNT=4):
1. Reset behaviour: rst_n=0 for 3 cycles mid-scan -> seg=7'h7F, an=3'b111, disp_valid=0. Release -> next edge an=3'b110, then an changes every 4 cycles 110->101->011->110.
2. Minimum value: load result=5'b10000 (-16) -> disp_valid high 2 edges later. Scan yields ones=7'h02 ('6'), tens=7'h79 ('1'), sign=7'h3F ('-').
3. Positive, zero and blanking: load +7 (5'b00111) -> ones=7'h78, tens=7'h7F, sign=7'h7F. Then load 0 -> ones=7'h40, tens and sign blank.
4. Error display: load=1 with err=1 and result=5'b01111 -> sign=7'h06 ('E'), tens=7'h2F, ones=7'h2F. A later load with err=0 and +15 -> sign blank, tens=7'h79, ones=7'h12.
5. Back-to-back loads: +15 then -1 on consecutive cycles -> digit registers show 15 at N+2 and -1 (sign=7'h3F, tens blank, ones=7'h79) at N+3. There is never a mixed state, and seg and an always change on the same edge.
